// File: rtl/slot_alloc_ctrl_if.sv
// Slot allocator bus: alloc grant handshake, commit/clear commands, abort,
// slot query port, and status/error outputs.
//   master : drives alloc_req, commit_*, clear_*, abort, qry_slot
//   slave  : drives alloc_valid/slot/addr, qry_*, valid_mask/count, err_*
interface slot_alloc_ctrl_if #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                    alloc_req;
  logic                    alloc_valid;
  logic [3:0]              alloc_slot;
  logic [ADDR_WIDTH-1:0]   alloc_addr;

  logic                    commit_req;
  logic [3:0]              commit_slot;
  logic [4:0]              commit_m;
  logic [4:0]              commit_n;
  logic [ADDR_WIDTH-1:0]   commit_addr;

  logic                    clear_req;
  logic [3:0]              clear_slot;

  logic                    abort;

  logic [3:0]              qry_slot;
  logic                    qry_valid;
  logic [4:0]              qry_m;
  logic [4:0]              qry_n;
  logic [ADDR_WIDTH-1:0]   qry_addr;

  logic [NUM_SLOTS-1:0]    valid_mask;
  logic [3:0]              valid_count;

  logic                    err_pulse;
  logic [1:0]              err_code;

  modport master (
    output alloc_req, commit_req, commit_slot, commit_m, commit_n, commit_addr,
           clear_req, clear_slot, abort, qry_slot,
    input  alloc_valid, alloc_slot, alloc_addr, qry_valid, qry_m, qry_n, qry_addr,
           valid_mask, valid_count, err_pulse, err_code
  );

  modport slave (
    input  alloc_req, commit_req, commit_slot, commit_m, commit_n, commit_addr,
           clear_req, clear_slot, abort, qry_slot,
    output alloc_valid, alloc_slot, alloc_addr, qry_valid, qry_m, qry_n, qry_addr,
           valid_mask, valid_count, err_pulse, err_code
  );
endinterface

// File: rtl/slot_alloc_ctrl.sv
// Matrix slot allocator: grants a free (or evicted) slot on request, holds a
// single open reservation until it is committed, cleared or aborted, keeps
// per-slot dimensions/address, and serves a registered lookup port.
// Ports: clk, rst_n (async active-low), bus (slot_alloc_ctrl_if.slave).
module slot_alloc_ctrl #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned SLOT_SIZE  = 256,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_DIM    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  slot_alloc_ctrl_if.slave   bus
);

  localparam int unsigned SLOT_W = 4;
  localparam int unsigned DIM_W  = 5;
  localparam int unsigned ERR_W  = 2;

  localparam logic [ERR_W-1:0] ERR_COMMIT_SLOT = 2'd1;
  localparam logic [ERR_W-1:0] ERR_DIMS        = 2'd2;
  localparam logic [ERR_W-1:0] ERR_CLEAR_SLOT  = 2'd3;

  // Slot regions must fit the BRAM address space without overlap.
  if (64'(NUM_SLOTS) * 64'(SLOT_SIZE) > (64'(1) << ADDR_WIDTH)) begin : g_bad_addr
    $error("NUM_SLOTS*SLOT_SIZE exceeds 2**ADDR_WIDTH");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > 15) begin : g_bad_slots
    $error("NUM_SLOTS must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_SLOTS-1:0]    valid_q, valid_d;
  logic                    resv_open_q, resv_open_d;
  logic [SLOT_W-1:0]       resv_slot_q, resv_slot_d;
  logic [SLOT_W-1:0]       evict_ptr_q, evict_ptr_d;
  logic [SLOT_W-1:0]       pick_slot_q, pick_slot_d;
  logic [DIM_W-1:0]        m_q [NUM_SLOTS];
  logic [DIM_W-1:0]        m_d [NUM_SLOTS];
  logic [DIM_W-1:0]        n_q [NUM_SLOTS];
  logic [DIM_W-1:0]        n_d [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0]   addr_q [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0]   addr_d [NUM_SLOTS];

  logic                    alloc_valid_q, alloc_valid_d;
  logic [SLOT_W-1:0]       alloc_slot_q, alloc_slot_d;
  logic [ADDR_WIDTH-1:0]   alloc_addr_q, alloc_addr_d;
  logic                    err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]        err_code_q, err_code_d;
  logic                    qry_valid_q, qry_valid_d;
  logic [DIM_W-1:0]        qry_m_q, qry_m_d;
  logic [DIM_W-1:0]        qry_n_q, qry_n_d;
  logic [ADDR_WIDTH-1:0]   qry_addr_q, qry_addr_d;
  logic [SLOT_W-1:0]       valid_count_q, valid_count_d;

  logic                    dims_ok;
  logic                    slot_match;
  logic                    free_found;
  logic [SLOT_W-1:0]       free_slot;

  // Next-state: clear, then commit (so a same-slot commit wins), then FSM, abort last.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    resv_open_d   = resv_open_q;
    resv_slot_d   = resv_slot_q;
    evict_ptr_d   = evict_ptr_q;
    pick_slot_d   = pick_slot_q;
    m_d           = m_q;
    n_d           = n_q;
    addr_d        = addr_q;
    alloc_valid_d = 1'b0;
    alloc_slot_d  = '0;
    alloc_addr_d  = '0;
    err_pulse_d   = 1'b0;
    err_code_d    = '0;
    qry_valid_d   = 1'b0;
    qry_m_d       = '0;
    qry_n_d       = '0;
    qry_addr_d    = '0;
    valid_count_d = '0;
    free_found    = 1'b0;
    free_slot     = '0;

    dims_ok    = (bus.commit_m >= DIM_W'(1)) && (bus.commit_m <= DIM_W'(MAX_DIM)) &&
                 (bus.commit_n >= DIM_W'(1)) && (bus.commit_n <= DIM_W'(MAX_DIM));
    slot_match = resv_open_q && (bus.commit_slot == resv_slot_q);

    if (bus.clear_req) begin
      if ({1'b0, bus.clear_slot} >= (SLOT_W + 1)'(NUM_SLOTS)) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_CLEAR_SLOT;
      end else begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (SLOT_W'(i) == bus.clear_slot) valid_d[i] = 1'b0;
        end
        if (resv_open_q && (resv_slot_q == bus.clear_slot)) resv_open_d = 1'b0;
      end
    end

    // A commit coincident with abort is silently dropped.
    if (bus.commit_req && !bus.abort) begin
      if (!slot_match) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_COMMIT_SLOT;
      end else if (!dims_ok) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_DIMS;
      end else begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (SLOT_W'(i) == bus.commit_slot) begin
            valid_d[i] = 1'b1;
            m_d[i]     = bus.commit_m;
            n_d[i]     = bus.commit_n;
            addr_d[i]  = bus.commit_addr;
          end
        end
        resv_open_d = 1'b0;
      end
    end

    // Lowest slot that is neither committed nor the open reservation.
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && !valid_q[i] && !(resv_open_q && (resv_slot_q == SLOT_W'(i)))) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.alloc_req && !bus.abort) begin
          state_d = ST_GRANT;
          if (free_found) begin
            pick_slot_d = free_slot;
          end else begin
            pick_slot_d = evict_ptr_q;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              if (SLOT_W'(i) == evict_ptr_q) valid_d[i] = 1'b0;
            end
            evict_ptr_d = (evict_ptr_q == SLOT_W'(NUM_SLOTS - 1)) ? '0
                                                                  : evict_ptr_q + SLOT_W'(1);
          end
        end
      end
      ST_GRANT: begin
        state_d = ST_WAIT_REL;
        if (!bus.abort) begin
          alloc_valid_d = 1'b1;
          alloc_slot_d  = pick_slot_q;
          alloc_addr_d  = ADDR_WIDTH'(pick_slot_q) * ADDR_WIDTH'(SLOT_SIZE);
          // Replaces any older reservation; that slot simply stays invalid.
          resv_open_d   = 1'b1;
          resv_slot_d   = pick_slot_q;
        end
      end
      ST_WAIT_REL: begin
        if (!bus.alloc_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      resv_open_d = 1'b0;
      state_d     = ST_IDLE;
    end

    // Status and lookup reflect post-edge state.
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      valid_count_d = valid_count_d + SLOT_W'(valid_d[i]);
      if (SLOT_W'(i) == bus.qry_slot) begin
        qry_valid_d = valid_d[i];
        qry_m_d     = m_d[i];
        qry_n_d     = n_d[i];
        qry_addr_d  = addr_d[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      resv_open_q   <= 1'b0;
      resv_slot_q   <= '0;
      evict_ptr_q   <= '0;
      pick_slot_q   <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        m_q[i]    <= '0;
        n_q[i]    <= '0;
        addr_q[i] <= '0;
      end
      alloc_valid_q <= 1'b0;
      alloc_slot_q  <= '0;
      alloc_addr_q  <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= '0;
      qry_valid_q   <= 1'b0;
      qry_m_q       <= '0;
      qry_n_q       <= '0;
      qry_addr_q    <= '0;
      valid_count_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      resv_open_q   <= resv_open_d;
      resv_slot_q   <= resv_slot_d;
      evict_ptr_q   <= evict_ptr_d;
      pick_slot_q   <= pick_slot_d;
      m_q           <= m_d;
      n_q           <= n_d;
      addr_q        <= addr_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_slot_q  <= alloc_slot_d;
      alloc_addr_q  <= alloc_addr_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      qry_valid_q   <= qry_valid_d;
      qry_m_q       <= qry_m_d;
      qry_n_q       <= qry_n_d;
      qry_addr_q    <= qry_addr_d;
      valid_count_q <= valid_count_d;
    end
  end

  assign bus.alloc_valid = alloc_valid_q;
  assign bus.alloc_slot  = alloc_slot_q;
  assign bus.alloc_addr  = alloc_addr_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_code    = err_code_q;
  assign bus.qry_valid   = qry_valid_q;
  assign bus.qry_m       = qry_m_q;
  assign bus.qry_n       = qry_n_q;
  assign bus.qry_addr    = qry_addr_q;
  assign bus.valid_mask  = valid_q;
  assign bus.valid_count = valid_count_q;

endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// Scoreboard bench for slot_alloc_ctrl: stimulus tasks queue the expected
// grants, errors and state snapshots; a negedge monitor pops and compares.
module tb_slot_alloc_ctrl;

  localparam int unsigned NS = 8;
  localparam int unsigned AW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slot_alloc_ctrl_if #(.NUM_SLOTS(NS), .ADDR_WIDTH(AW)) bus ();

  slot_alloc_ctrl #(
    .NUM_SLOTS(NS), .SLOT_SIZE(256), .ADDR_WIDTH(AW), .MAX_DIM(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]    slot;
    logic [AW-1:0] addr;
  } alloc_t;

  typedef struct {
    logic [NS-1:0] mask;
    logic [3:0]    cnt;
    logic          qv;
    logic [4:0]    qm;
    logic [4:0]    qn;
    logic [AW-1:0] qa;
    logic          quiet;   // also require grant/error outputs to be zero
  } snap_t;

  alloc_t     exp_alloc[$];
  logic [1:0] exp_err[$];
  snap_t      exp_snap[$];
  logic       snap_req = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every observed pulse and every requested snapshot.
  always @(negedge clk) begin
    if (bus.alloc_valid === 1'b1) begin
      if (exp_alloc.size() == 0) begin
        chk("alloc_unexpected", 32'(bus.alloc_slot), 32'hFFFF);
      end else begin
        alloc_t a;
        a = exp_alloc.pop_front();
        chk("alloc_slot", 32'(bus.alloc_slot), 32'(a.slot));
        chk("alloc_addr", 32'(bus.alloc_addr), 32'(a.addr));
      end
    end
    if (bus.err_pulse === 1'b1) begin
      if (exp_err.size() == 0) begin
        chk("err_unexpected", 32'(bus.err_code), 32'hFFFF);
      end else begin
        logic [1:0] e;
        e = exp_err.pop_front();
        chk("err_code", 32'(bus.err_code), 32'(e));
      end
    end
    if (snap_req && exp_snap.size() != 0) begin
      snap_t s;
      s = exp_snap.pop_front();
      chk("valid_mask",  32'(bus.valid_mask),  32'(s.mask));
      chk("valid_count", 32'(bus.valid_count), 32'(s.cnt));
      chk("qry_valid",   32'(bus.qry_valid),   32'(s.qv));
      chk("qry_m",       32'(bus.qry_m),       32'(s.qm));
      chk("qry_n",       32'(bus.qry_n),       32'(s.qn));
      chk("qry_addr",    32'(bus.qry_addr),    32'(s.qa));
      if (s.quiet) begin
        chk("q_alloc_valid", 32'(bus.alloc_valid), 32'h0);
        chk("q_alloc_slot",  32'(bus.alloc_slot),  32'h0);
        chk("q_alloc_addr",  32'(bus.alloc_addr),  32'h0);
        chk("q_err_pulse",   32'(bus.err_pulse),   32'h0);
        chk("q_err_code",    32'(bus.err_code),    32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_qry(input logic [3:0] s);
    bus.qry_slot = s;
    tick();
  endtask

  task automatic snap(input logic [NS-1:0] mask, input logic [3:0] cnt, input logic qv,
                      input logic [4:0] qm, input logic [4:0] qn, input logic [AW-1:0] qa,
                      input logic quiet);
    exp_snap.push_back('{mask: mask, cnt: cnt, qv: qv, qm: qm, qn: qn, qa: qa, quiet: quiet});
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  // Hold alloc_req for 'hold' cycles, then wait for the FSM to return to IDLE.
  task automatic do_alloc(input logic [3:0] s, input int hold);
    logic [AW-1:0] a;
    a = AW'(s) << 8;
    exp_alloc.push_back('{slot: s, addr: a});
    bus.alloc_req = 1'b1;
    repeat (hold) tick();
    bus.alloc_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_commit(input logic [3:0] s, input logic [4:0] m, input logic [4:0] n,
                           input logic [AW-1:0] a, input logic [1:0] err);
    if (err != 2'd0) exp_err.push_back(err);
    bus.commit_req  = 1'b1;
    bus.commit_slot = s;
    bus.commit_m    = m;
    bus.commit_n    = n;
    bus.commit_addr = a;
    tick();
    bus.commit_req  = 1'b0;
  endtask

  task automatic do_clear(input logic [3:0] s, input logic [1:0] err);
    if (err != 2'd0) exp_err.push_back(err);
    bus.clear_req  = 1'b1;
    bus.clear_slot = s;
    tick();
    bus.clear_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alloc_req   = 1'b0;
    bus.commit_req  = 1'b0;
    bus.commit_slot = '0;
    bus.commit_m    = '0;
    bus.commit_n    = '0;
    bus.commit_addr = '0;
    bus.clear_req   = 1'b0;
    bus.clear_slot  = '0;
    bus.abort       = 1'b0;
    bus.qry_slot    = '0;

    // Reset state: everything zero.
    tick();
    snap(8'h00, 4'd0, 1'b0, 5'd0, 5'd0, 12'h000, 1'b1);
    rst_n = 1'b1;
    tick();

    // Held request gives one grant of slot 0; commit 3x4 at 0.
    do_alloc(4'd0, 3);
    do_commit(4'd0, 5'd3, 5'd4, 12'h000, 2'd0);
    snap(8'h01, 4'd1, 1'b1, 5'd3, 5'd4, 12'h000, 1'b0);

    // Fill slots 1..7 (slot 7 gets boundary dims 16x1).
    for (int s = 1; s < 8; s++) begin
      do_alloc(4'(s), 1);
      do_commit(4'(s), 5'(s + 9), 5'(8 - s), AW'(s) << 8, 2'd0);
    end
    snap(8'hFF, 4'd8, 1'b1, 5'd3, 5'd4, 12'h000, 1'b0);
    set_qry(4'd7);
    do_alloc(4'd0, 1);                                    // evicts slot 0
    snap(8'hFE, 4'd7, 1'b1, 5'd16, 5'd1, 12'h700, 1'b0);
    do_alloc(4'd1, 1);                                    // drops slot 0 reservation, evicts 1
    snap(8'hFC, 4'd6, 1'b1, 5'd16, 5'd1, 12'h700, 1'b0);

    // Rejected commits while slot 1 is reserved.
    do_commit(4'd2, 5'd3, 5'd3, 12'h200, 2'd1);
    do_commit(4'd1, 5'd0, 5'd3, 12'h100, 2'd2);
    do_commit(4'd1, 5'd17, 5'd3, 12'h100, 2'd2);
    do_commit(4'd1, 5'd3, 5'd0, 12'h100, 2'd2);
    set_qry(4'd2);
    snap(8'hFC, 4'd6, 1'b1, 5'd11, 5'd6, 12'h200, 1'b0);

    // Clear + commit same slot: commit wins, no error.
    set_qry(4'd1);
    bus.clear_req  = 1'b1;
    bus.clear_slot = 4'd1;
    do_commit(4'd1, 5'd2, 5'd5, 12'h100, 2'd0);
    bus.clear_req  = 1'b0;
    snap(8'hFE, 4'd7, 1'b1, 5'd2, 5'd5, 12'h100, 1'b0);
    do_clear(4'd9, 2'd3);
    snap(8'hFE, 4'd7, 1'b1, 5'd2, 5'd5, 12'h100, 1'b0);
    do_clear(4'd3, 2'd0);
    snap(8'hF6, 4'd6, 1'b1, 5'd2, 5'd5, 12'h100, 1'b0);
    do_commit(4'd1, 5'd4, 5'd4, 12'h100, 2'd1);           // no reservation open
    set_qry(4'd9);
    snap(8'hF6, 4'd6, 1'b0, 5'd0, 5'd0, 12'h000, 1'b0);

    // Abort in WAIT_REL together with a commit: commit discarded, no error.
    set_qry(4'd2);
    exp_alloc.push_back('{slot: 4'd0, addr: 12'h000});
    bus.alloc_req = 1'b1;
    repeat (3) tick();
    bus.alloc_req   = 1'b0;
    bus.abort       = 1'b1;
    bus.commit_req  = 1'b1;
    bus.commit_slot = 4'd0;
    bus.commit_m    = 5'd2;
    bus.commit_n    = 5'd2;
    bus.commit_addr = 12'h000;
    tick();
    bus.abort      = 1'b0;
    bus.commit_req = 1'b0;
    snap(8'hF6, 4'd6, 1'b1, 5'd11, 5'd6, 12'h200, 1'b0);
    do_commit(4'd0, 5'd1, 5'd1, 12'h000, 2'd1);           // reservation closed
    do_alloc(4'd0, 1);
    do_commit(4'd0, 5'd5, 5'd5, 12'h000, 2'd0);
    do_clear(4'd5, 2'd0);
    do_alloc(4'd3, 1);
    do_commit(4'd3, 5'd6, 5'd6, 12'h300, 2'd0);
    do_alloc(4'd5, 1);                                    // slot 5 left reserved
    snap(8'hDF, 4'd7, 1'b1, 5'd11, 5'd6, 12'h200, 1'b0);

    // One-cycle reset pulse with an open reservation.
    rst_n = 1'b0;
    snap(8'h00, 4'd0, 1'b0, 5'd0, 5'd0, 12'h000, 1'b1);
    rst_n = 1'b1;
    tick();
    snap(8'h00, 4'd0, 1'b0, 5'd0, 5'd0, 12'h000, 1'b1);
    do_alloc(4'd0, 1);
    do_commit(4'd0, 5'd7, 5'd7, 12'h000, 2'd0);
    set_qry(4'd0);
    snap(8'h01, 4'd1, 1'b1, 5'd7, 5'd7, 12'h000, 1'b0);

    repeat (3) tick();
    while (exp_alloc.size() != 0) begin
      void'(exp_alloc.pop_front());
      chk("alloc_missing", 32'h0, 32'h1);
    end
    while (exp_err.size() != 0) begin
      void'(exp_err.pop_front());
      chk("err_missing", 32'h0, 32'h1);
    end
    while (exp_snap.size() != 0) begin
      void'(exp_snap.pop_front());
      chk("snap_missing", 32'h0, 32'h1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
